// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program into instruction memory, holds the core in reset,
// releases it to run, and stops it on a halt instruction or when the cycle budget runs out.
module boot_sequencer #(
    parameter int                 INST_W     = 16,
    parameter int                 ADDR_W     = 8,
    parameter int                 RST_HOLD   = 4,
    parameter int                 MAX_CYCLES = 1024,
    parameter logic [INST_W-1:0]  HALT_WORD  = {INST_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [INST_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_rst,
    input  logic [INST_W-1:0] cpu_inst,
    input  logic              cpu_inst_vld,
    output logic [ADDR_W:0]   words_loaded,
    output logic [31:0]       run_cycles,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [31:0]       RUN_LAST  = 32'(MAX_CYCLES - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
            ld_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            imem_wdata   <= {INST_W{1'b0}};
            cpu_rst      <= 1'b1;
            words_loaded <= {(ADDR_W+1){1'b0}};
            run_cycles   <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_r      <= S_LOAD;
                        addr_r       <= {ADDR_W{1'b0}};
                        words_loaded <= {(ADDR_W+1){1'b0}};
                        run_cycles   <= 32'd0;
                        done         <= 1'b0;
                        timeout      <= 1'b0;
                        overflow     <= 1'b0;
                        ld_ready     <= 1'b1;
                        busy         <= 1'b1;
                        cpu_rst      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // ld_ready is high throughout LOAD, so ld_valid alone is the handshake.
                    if (ld_valid) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= addr_r;
                        imem_wdata   <= ld_data;
                        words_loaded <= words_loaded + WORD_ONE;
                        if (ld_last || (addr_r == ADDR_MAX)) begin
                            state_r    <= S_HOLD;
                            ld_ready   <= 1'b0;
                            overflow   <= ~ld_last;
                            hold_cnt_r <= {HOLD_W{1'b0}};
                        end else begin
                            addr_r <= addr_r + ADDR_ONE;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r <= S_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                S_RUN: begin
                    // The ending cycle does not count, so a budget stop reports MAX_CYCLES-1.
                    if (cpu_inst_vld && (cpu_inst == HALT_WORD)) begin
                        state_r <= S_DONE;
                        timeout <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cpu_rst <= 1'b1;
                    end else if (run_cycles == RUN_LAST) begin
                        state_r <= S_DONE;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cpu_rst <= 1'b1;
                    end else if (run_cycles != 32'hFFFF_FFFF) begin
                        run_cycles <= run_cycles + 32'd1;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    ld_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_rst  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: a procedural timeline model predicts every
// output cycle by cycle while random programs, gaps and halt points are driven.
module tb_boot_sequencer;

    localparam int          INST_W     = 16;
    localparam int          ADDR_W     = 3;
    localparam int          DEPTH      = 1 << ADDR_W;
    localparam int          RST_HOLD   = 4;
    localparam int          MAX_CYCLES = 16;
    localparam logic [15:0] HALT       = 16'hFFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [INST_W-1:0] ld_data = 16'h0000;
    logic              ld_last = 1'b0;
    logic [INST_W-1:0] cpu_inst = 16'h0000;
    logic              cpu_inst_vld = 1'b0;
    logic              ld_ready, imem_we, cpu_rst, busy, done, timeout, overflow;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic [31:0]       run_cycles;

    boot_sequencer #(
        .INST_W(INST_W), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD),
        .MAX_CYCLES(MAX_CYCLES), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .cpu_inst(cpu_inst),
        .cpu_inst_vld(cpu_inst_vld), .words_loaded(words_loaded), .run_cycles(run_cycles),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic check_en = 1'b0;

    // Expected outputs for the current cycle, written by the stimulus script.
    logic              e_rdy, e_crst, e_busy, e_done, e_to, e_ovf, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [INST_W-1:0] e_wdata;
    logic [ADDR_W:0]   e_words;
    logic [31:0]       e_runc;

    logic [INST_W-1:0] prog [16];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [INST_W-1:0] wr_data_q [$];
    int                hold_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_exp();
        e_rdy = 1'b0; e_crst = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_to = 1'b0;
        e_ovf = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_words = '0; e_runc = 32'd0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("ld_ready", 32'(ld_ready), 32'(e_rdy));
            chk("cpu_rst", 32'(cpu_rst), 32'(e_crst));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("timeout", 32'(timeout), 32'(e_to));
            chk("overflow", 32'(overflow), 32'(e_ovf));
            chk("imem_we", 32'(imem_we), 32'(e_we));
            chk("words_loaded", 32'(words_loaded), 32'(e_words));
            chk("run_cycles", run_cycles, e_runc);
            if (e_we) begin
                chk("imem_addr", 32'(imem_addr), 32'(e_addr));
                chk("imem_wdata", 32'(imem_wdata), 32'(e_wdata));
            end
        end
    end

    // Records actual writes and the length of the last reset-hold window.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (ld_ready === 1'b1) hold_len <= 0;
        else if (busy === 1'b1 && cpu_rst === 1'b1) hold_len <= hold_len + 1;
    end

    // mode: 0 random gaps, 1 valid every other cycle, 2 valid every cycle.
    task automatic run_prog(input int n, input bit use_last, input int mode,
                            input int halt_at, input int rst_at);
        int k;
        int alt;
        int e_end;
        bit fin;
        bit v;
        e_end = (halt_at < MAX_CYCLES - 1) ? halt_at : MAX_CYCLES - 1;
        e_we = 1'b0;
        start = 1'b1; ld_valid = 1'b1; ld_data = 16'h1234; ld_last = 1'b1; cpu_inst_vld = 1'b0;
        step();
        e_rdy = 1'b1; e_busy = 1'b1; e_done = 1'b0; e_to = 1'b0; e_ovf = 1'b0;
        e_words = '0; e_runc = 32'd0; e_we = 1'b0;
        k = 0; fin = 1'b0; alt = 0;
        while (!fin) begin
            case (mode)
                0:       v = ($urandom_range(99) >= 35);
                1:       v = ((alt % 2) == 1);
                default: v = 1'b1;
            endcase
            alt++;
            ld_valid = v; ld_data = prog[k]; ld_last = use_last && (k == n - 1);
            start = 1'($urandom_range(1)); cpu_inst = HALT; cpu_inst_vld = 1'b1;
            step();
            e_we = 1'b0;
            if (v) begin
                e_we = 1'b1; e_addr = ADDR_W'(k); e_wdata = prog[k]; e_words = (ADDR_W+1)'(k + 1);
                if (ld_last || k == DEPTH - 1) begin
                    fin = 1'b1;
                    e_ovf = ~ld_last;
                end
                k++;
            end
        end
        e_rdy = 1'b0;
        // Loader keeps offering a word and the core shows a halt: both must be ignored.
        for (int i = 0; i < RST_HOLD; i++) begin
            ld_valid = 1'b1; ld_data = prog[k]; ld_last = 1'b0;
            start = 1'($urandom_range(1)); cpu_inst = HALT; cpu_inst_vld = 1'b1;
            step();
            e_we = 1'b0;
        end
        for (int j = 0; j <= e_end; j++) begin
            e_crst = 1'b0; e_runc = 32'(j);
            if (j == rst_at) begin
                #2 rst = 1'b0;
                #1;
                set_reset_exp();
                chk("async_cpu_rst", 32'(cpu_rst), 32'd1);
                chk("async_busy", 32'(busy), 32'd0);
                chk("async_run_cycles", run_cycles, 32'd0);
                chk("async_words", 32'(words_loaded), 32'd0);
                return;
            end
            if (j == halt_at) begin
                cpu_inst = HALT; cpu_inst_vld = 1'b1;
            end else if ($urandom_range(3) == 0) begin
                cpu_inst = HALT; cpu_inst_vld = 1'b0;
            end else begin
                cpu_inst = 16'($urandom_range(65534)); cpu_inst_vld = 1'($urandom_range(1));
            end
            start = 1'($urandom_range(1)); ld_valid = 1'($urandom_range(1));
            step();
        end
        e_crst = 1'b1; e_busy = 1'b0; e_done = 1'b1;
        e_to = (halt_at != e_end); e_runc = 32'(e_end);
        start = 1'b0; cpu_inst_vld = 1'b0; ld_valid = 1'b1;
        step();
        step();
    endtask

    task automatic load_prog5();
        prog[0] = 16'h2281; prog[1] = 16'h2142; prog[2] = 16'h00D1;
        prog[3] = 16'h8002; prog[4] = 16'h4041;
        for (int i = 5; i < 16; i++) prog[i] = 16'($urandom_range(65534));
    endtask

    task automatic chk_writes(input string name, input int n);
        chk({name, "_count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk({name, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({name, "_data"}, 32'(wr_data_q[i]), 32'(prog[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_reset_exp();
        #2 rst = 1'b0;
        #1;
        check_en = 1'b1;
        chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reset_ld_ready", 32'(ld_ready), 32'd0);
        chk("reset_imem_we", 32'(imem_we), 32'd0);
        chk("reset_imem_addr", 32'(imem_addr), 32'd0);
        step(); step();
        rst = 1'b1; ld_valid = 1'b1;
        step(); step(); step();

        // Five-word program, halt on run cycle 7.
        load_prog5();
        wr_addr_q.delete(); wr_data_q.delete();
        run_prog(5, 1'b1, 2, 7, -1);
        chk("a_words", 32'(words_loaded), 32'd5);
        chk("a_run_cycles", run_cycles, 32'd7);
        chk("a_timeout", 32'(timeout), 32'd0);
        chk("a_done", 32'(done), 32'd1);
        chk("a_hold_len", 32'(hold_len), 32'd4);
        chk_writes("a_wr", 5);

        // Alternating valid, no halt: budget stop.
        wr_addr_q.delete(); wr_data_q.delete();
        run_prog(5, 1'b1, 1, 100, -1);
        chk("b_run_cycles", run_cycles, 32'd15);
        chk("b_timeout", 32'(timeout), 32'd1);
        chk_writes("b_wr", 5);

        // Halt on the budget's last cycle wins.
        run_prog(5, 1'b1, 0, 15, -1);
        chk("c_run_cycles", run_cycles, 32'd15);
        chk("c_timeout", 32'(timeout), 32'd0);

        // Nine words, no ld_last: memory fills.
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom_range(65535));
        wr_addr_q.delete(); wr_data_q.delete();
        run_prog(9, 1'b0, 0, 3, -1);
        chk("d_words", 32'(words_loaded), 32'd8);
        chk("d_overflow", 32'(overflow), 32'd1);
        chk_writes("d_wr", 8);

        // Reset during run cycle 3, then a clean reload.
        load_prog5();
        run_prog(5, 1'b1, 2, 7, 3);
        step(); step();
        rst = 1'b1;
        step();
        run_prog(5, 1'b1, 2, 7, -1);
        chk("e_run_cycles", run_cycles, 32'd7);
        chk("e_done", 32'(done), 32'd1);

        for (int t = 0; t < 10; t++) begin
            int n;
            bit lst;
            n = $urandom_range(10, 1);
            for (int i = 0; i < 16; i++) prog[i] = 16'($urandom_range(65535));
            lst = (n <= DEPTH) ? 1'b1 : 1'($urandom_range(1));
            run_prog(n, lst, $urandom_range(2), $urandom_range(20), -1);
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
